// File: rtl/booth_r4_pkg.sv
// Shared encodings for the radix-4 Booth multiplier family: controller states
// and the Booth digit select codes produced by the digit decoder.
package booth_r4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } digit_t;

endpackage

// File: rtl/booth_r4_digit.sv
// Radix-4 Booth digit decoder: {q[i+1], q[i], q[i-1]} -> signed digit select.
// Purely combinational so the array multiplier can instance one per row.
module booth_r4_digit
  import booth_r4_pkg::*;
(
  input  logic [2:0] bits,
  output digit_t     digit
);

  always_comb begin
    digit = ZERO;
    unique case (bits)
      3'b000, 3'b111: digit = ZERO;
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult.sv
// Self-sequenced radix-4 Booth multiplier: one Booth digit per clock, with a
// start/busy/done handshake and a product register held between completions.
module booth_r4_mult
  import booth_r4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int EW   = WIDTH + 2;   // extended operand width
  localparam int AW   = WIDTH + 4;   // accumulator width, holds +/-2Mx
  localparam int CW   = $clog2(ITER + 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("booth_r4_mult: WIDTH must be even and >= 4");
  end

  state_t          state, state_nxt;
  logic [AW-1:0]   acc, mx, addend, a_sum;
  logic [EW-1:0]   q_reg, m_ext, q_ext;
  logic            q_1;
  logic [CW-1:0]   count;
  digit_t          digit;
  logic            accept, last;
  logic signed [AW+EW:0] cat, shifted;

  assign accept = start && (state != CALC);
  assign last   = (state == CALC) && (count == CW'(1));

  // Two guard bits make the unsigned case a non-negative signed operand.
  assign m_ext = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
  assign q_ext = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  booth_r4_digit u_digit (
    .bits  ({q_reg[1:0], q_1}),
    .digit (digit)
  );

  always_comb begin
    addend = '0;
    unique case (digit)
      ZERO:    addend = '0;
      POS1:    addend = mx;
      POS2:    addend = {mx[AW-2:0], 1'b0};
      NEG1:    addend = -mx;
      NEG2:    addend = -{mx[AW-2:0], 1'b0};
      default: addend = '0;
    endcase
  end

  assign a_sum   = acc + addend;
  assign cat     = {a_sum, q_reg, q_1};
  assign shifted = cat >>> 2;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      mx      <= '0;
      q_reg   <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      product <= '0;
    end else if (accept) begin
      acc   <= '0;
      mx    <= {{2{m_ext[EW-1]}}, m_ext};
      q_reg <= q_ext;
      q_1   <= 1'b0;
      count <= CW'(ITER);
    end else if (state == CALC) begin
      acc   <= shifted[AW+EW:EW+1];
      q_reg <= shifted[EW:1];
      q_1   <= shifted[0];
      count <= count - CW'(1);
      if (last) product <= shifted[2*WIDTH:1];
    end
  end

endmodule

// File: doc/booth_r4_mult.md
Name: booth_r4_mult

Overview:
- Parametrised, self-sequenced radix-4 Booth multiplier with an integrated controller.
- Generalises the fixed 8x8 signed Booth datapath and its external ld/sel controller into one block with:
  - a WIDTH parameter;
  - a runtime signed/unsigned mode;
  - a start/busy/done handshake;
  - a held product register.
- Sits beside the ALU. One 2-bit Booth digit is retired per clock.

Parameters:
- WIDTH, 8, operand width in bits.
  - Must be even and at least 4; elaboration error otherwise.
- ITER, WIDTH/2+1, derived localparam, not overridable. Number of Booth iterations.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin a multiply. Sampled only when busy=0 (IDLE or DONE).
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned. Sampled with start.
- multiplicand  input  WIDTH  operand M. Sampled with start.
- multiplier  input  WIDTH  operand Q. Sampled with start.
- busy  output  1  high while iterating.
- done  output  1  single-cycle pulse; product valid.
- product  output  2*WIDTH  result register. Holds its value until the next completion.

Behaviour:
- Reset (rst=1 at a clk edge), from any state including mid-operation:
  - state <= IDLE;
  - busy, done, product, internal A, Q, q_1 and count all <= 0.
- States:
  - IDLE: busy=0, done=0.
  - CALC: busy=1, done=0.
  - DONE: busy=0, done=1, one cycle only.
- Transitions:
  - IDLE --start--> CALC.
  - CALC --count reaches 0 after the iteration--> DONE.
  - DONE --start--> CALC, back-to-back; otherwise DONE --> IDLE.
  - start while in CALC is ignored. Operands and mode are not re-sampled.
- Load (edge where start is accepted):
  - Operands are extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended if 0.
  - Registers take:
    - Mx = extended M, further sign-extended to the A width;
    - A = 0, width WIDTH+4;
    - Q = extended multiplier;
    - q_1 = 0;
    - count = ITER.
- Iteration (each CALC edge):
  - The digit from {Q[1],Q[0],q_1} selects the addend:
    - 000, 111 -> 0;
    - 001, 010 -> +Mx;
    - 011 -> +2Mx;
    - 100 -> -2Mx;
    - 101, 110 -> -Mx.
  - A' = A + addend, computed in two's complement at A width.
  - Then {A,Q,q_1} <= arithmetic right shift by 2 of {A',Q,q_1}, with the sign of A' replicated.
  - count decrements by 1.
- Completion (the edge performing the last iteration, count==1):
  - product <= low 2*WIDTH bits of the shifted {A,Q}.
  - state <= DONE.
- Latency and throughput:
  - done is high in the cycle after the ITER-th edge following the start edge: 5 edges for WIDTH=8.
  - A new start may be accepted in the DONE cycle, giving throughput of one result per ITER+1 cycles.
- Result correctness: every operand pair produces the exact 2*WIDTH-bit product, for both modes, including these corner cases:
  - signed most-negative times most-negative;
  - unsigned max times max;
  - either operand 0.
- product is unchanged during CALC. It is updated only at completion or by reset.

Decomposition:
- Package booth_r4_pkg holds:
  - state encoding constants IDLE/CALC/DONE (2 bits);
  - Booth digit select encoding: ZERO, POS1, POS2, NEG1, NEG2.
- Sub-module booth_r4_digit: combinational decoder, 3 bits in, digit code out.
  - Reused by the later array multiplier.
- Everything else lives in booth_r4_mult: the FSM, count, A/Q/q_1 registers, addend mux, adder and shift.

Test Plan:
- WIDTH=8, signed, -128 x -128, start for one cycle:
  - busy high for 5 cycles;
  - done pulses once in the 6th cycle;
  - product=16'h4000.
- WIDTH=8:
  - unsigned 255 x 255 -> product=16'hFE01;
  - signed 3 x -5 -> 16'hFFF1;
  - signed 0 x -1 -> 16'h0000.
- WIDTH=16, signed, -32768 x 32767 -> product=32'hC0008000. The done pulse arrives 9 edges after the start edge.
- Start raised again two cycles after the first start with different operands:
  - the second start is ignored;
  - product equals the first result;
  - exactly one done pulse.
- Start asserted during the DONE cycle with 7 x 9 (unsigned): accepted; product=16'h003F after a further 5 edges.
- rst=1 on the third CALC edge:
  - next cycle busy=0, done=0, product=0;
  - a subsequent 2 x 2 returns 16'h0004.
